axi_lite_master_arb: RTL and testbench
======================================

// Module: axi_lite_master_arb
// PURPOSE
//  Two-requester AXI4-Lite master. Round-robin arbitrates single-beat read/write commands from two local clients
//  and issues them, one transaction at a time, to one AXI4-Lite slave register block (4 x 32-bit regs at 0x0..0xC).
//  Sits between the control clients and the slave; owns all AXI master-side sequencing.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  32  AXI data width; C_REQ_WSTRB width = DW/8
//  C_M_AXI_ADDR_WIDTH  4   AXI address width
// PORTS
//  M_AXI_ACLK       in   1        clock; everything on its rising edge
//  M_AXI_ARESET     in   1        reset, asynchronous assert, active-high
//  C_REQ_VALID      in   2        per-requester command valid; requester i holds its fields stable until C_REQ_READY[i]
//  C_REQ_READY      out  2        one-cycle command accept pulse
//  C_REQ_WR         in   2        1 = write, 0 = read
//  C_REQ_ADDR       in   2*AW     requester i in [i*AW +: AW]
//  C_REQ_WDATA      in   2*DW     requester i in [i*DW +: DW]
//  C_REQ_WSTRB      in   2*DW/8   requester i in [i*DW/8 +: DW/8]
//  C_RSP_VALID      out  2        one-cycle completion pulse to owning requester; no backpressure
//  C_RSP_RDATA      out  DW       read data (0 for writes); valid with C_RSP_VALID
//  C_RSP_RESP       out  2        BRESP/RRESP of the completed transaction
//  M_AXI_AW_ADDR/_PROT/_VALID out AW/3/1; M_AXI_AW_READY in 1
//  M_AXI_W_DATA/_STRB/_VALID  out DW/DW/8/1; M_AXI_W_READY in 1
//  M_AXI_B_RESP in 2; M_AXI_B_VALID in 1; M_AXI_B_READY out 1
//  M_AXI_AR_ADDR/_PROT/_VALID out AW/3/1; M_AXI_AR_READY in 1
//  M_AXI_R_DATA in DW; M_AXI_R_RESP in 2; M_AXI_R_VALID in 1; M_AXI_R_READY out 1
// BEHAVIOUR
//  Reset: all outputs 0 (all VALID/READY low, addr/data/resp 0, PROT 3'b000 always); state IDLE; last_grant=1.
//  FSM: IDLE -> WR_AW_W -> WR_B -> RSP -> IDLE; IDLE -> RD_AR -> RD_R -> RSP -> IDLE.
//  IDLE: if any C_REQ_VALID, grant g: single requester wins; both -> g = ~last_grant; last_grant <= g.
//   Same edge: latch wr/addr/wdata/wstrb of g; C_REQ_READY[g] <= 1 (high exactly one cycle);
//   write: AW_VALID<=1, W_VALID<=1 -> WR_AW_W; read: AR_VALID<=1 -> RD_AR.
//  WR_AW_W: AW_VALID drops edge after AW_VALID&AW_READY, W_VALID independently after W_VALID&W_READY;
//   either order or simultaneous. Both done -> WR_B with B_READY=1. VALID never dropped before handshake.
//  WR_B: on B_VALID&B_READY: capture B_RESP, B_READY<=0, -> RSP.
//  RD_AR: on AR_VALID&AR_READY: AR_VALID<=0, R_READY<=1 -> RD_R.
//  RD_R: on R_VALID&R_READY: capture R_DATA/R_RESP, R_READY<=0 -> RSP.
//  RSP: C_RSP_VALID[g]=1 one cycle with RDATA/RESP; -> IDLE. RDATA/RESP hold until next RSP.
//  One outstanding transaction max; other requester waits, C_REQ_READY low.
//  Min latency, zero-wait slave: req accepted cycle 1, write C_RSP_VALID at cycle 4, read at cycle 4.
//  Requester holding VALID after its READY = next command; arbitrated normally in next IDLE.
//  Non-OKAY responses passed through unchanged; no retry.
//  Reset mid-transaction: immediate return to IDLE, all outputs reset; slave must share the reset.
// CONFIGURATION
//  AXI_ARB_STATS_EN defined: adds outputs STAT_CNT0, STAT_CNT1 (out, 16 each): completed-transaction counts per
//   requester, +1 on each C_RSP_VALID[i], saturate at 16'hFFFF, reset 0; plus STAT_ERR (out 16): count of RSP with
//   RESP != 2'b00, saturating.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Req0 write addr 0x4 data 0xA5A5_1234 strb 4'hF, then req0 read 0x4 -> C_RSP_RDATA 0xA5A5_1234, RESP 2'b00.
//  Req0/req1 both valid from reset, 4 cmds each -> grant order 0,1,0,1,0,1,0,1; no starvation.
//  Slave AW_READY 3 cycles before W_READY, and reverse, and simultaneous -> each VALID held to own handshake, 1 B.
//  Write strb 4'b0010 data 0xFFFF_FFFF to reg 0x8 (reset 0x2) -> readback 0x0000_FF02.
//  Slave delays B_VALID 5 cycles, R_VALID 7 cycles with RESP 2'b10 -> B/R_READY held; C_RSP_RESP 2'b10.
//  Reset asserted in WR_B -> all VALID/READY 0 within same cycle; with STATS_EN counters read 0 afterwards.

Source files
------------

// File: rtl/axi_lite_master_arb_if.sv
// Bundles the client command/response signals and the AXI4-Lite master
// channels of axi_lite_master_arb. The arbiter uses "master"; the environment uses "slave".
interface axi_lite_master_arb_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [1:0]          C_REQ_VALID;
  logic [1:0]          C_REQ_READY;
  logic [1:0]          C_REQ_WR;
  logic [2*AW-1:0]     C_REQ_ADDR;
  logic [2*DW-1:0]     C_REQ_WDATA;
  logic [2*DW/8-1:0]   C_REQ_WSTRB;
  logic [1:0]          C_RSP_VALID;
  logic [DW-1:0]       C_RSP_RDATA;
  logic [1:0]          C_RSP_RESP;

  logic [AW-1:0]       M_AXI_AW_ADDR;
  logic [2:0]          M_AXI_AW_PROT;
  logic                M_AXI_AW_VALID;
  logic                M_AXI_AW_READY;
  logic [DW-1:0]       M_AXI_W_DATA;
  logic [DW/8-1:0]     M_AXI_W_STRB;
  logic                M_AXI_W_VALID;
  logic                M_AXI_W_READY;
  logic [1:0]          M_AXI_B_RESP;
  logic                M_AXI_B_VALID;
  logic                M_AXI_B_READY;
  logic [AW-1:0]       M_AXI_AR_ADDR;
  logic [2:0]          M_AXI_AR_PROT;
  logic                M_AXI_AR_VALID;
  logic                M_AXI_AR_READY;
  logic [DW-1:0]       M_AXI_R_DATA;
  logic [1:0]          M_AXI_R_RESP;
  logic                M_AXI_R_VALID;
  logic                M_AXI_R_READY;

  modport master (
    input  C_REQ_VALID, C_REQ_WR, C_REQ_ADDR, C_REQ_WDATA, C_REQ_WSTRB,
    output C_REQ_READY, C_RSP_VALID, C_RSP_RDATA, C_RSP_RESP,
    output M_AXI_AW_ADDR, M_AXI_AW_PROT, M_AXI_AW_VALID,
    input  M_AXI_AW_READY,
    output M_AXI_W_DATA, M_AXI_W_STRB, M_AXI_W_VALID,
    input  M_AXI_W_READY,
    input  M_AXI_B_RESP, M_AXI_B_VALID,
    output M_AXI_B_READY,
    output M_AXI_AR_ADDR, M_AXI_AR_PROT, M_AXI_AR_VALID,
    input  M_AXI_AR_READY,
    input  M_AXI_R_DATA, M_AXI_R_RESP, M_AXI_R_VALID,
    output M_AXI_R_READY
  );

  modport slave (
    output C_REQ_VALID, C_REQ_WR, C_REQ_ADDR, C_REQ_WDATA, C_REQ_WSTRB,
    input  C_REQ_READY, C_RSP_VALID, C_RSP_RDATA, C_RSP_RESP,
    input  M_AXI_AW_ADDR, M_AXI_AW_PROT, M_AXI_AW_VALID,
    output M_AXI_AW_READY,
    input  M_AXI_W_DATA, M_AXI_W_STRB, M_AXI_W_VALID,
    output M_AXI_W_READY,
    output M_AXI_B_RESP, M_AXI_B_VALID,
    input  M_AXI_B_READY,
    input  M_AXI_AR_ADDR, M_AXI_AR_PROT, M_AXI_AR_VALID,
    output M_AXI_AR_READY,
    output M_AXI_R_DATA, M_AXI_R_RESP, M_AXI_R_VALID,
    input  M_AXI_R_READY
  );
endinterface

// File: rtl/axi_lite_master_arb.sv
// Two-client round-robin AXI4-Lite master, one transaction in flight at a time.
// Define AXI_ARB_STATS_EN to add per-requester completion and error counters.
module axi_lite_master_arb #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  axi_lite_master_arb_if.master bus
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [15:0]           STAT_CNT0,
  output logic [15:0]           STAT_CNT1,
  output logic [15:0]           STAT_ERR
`endif
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_RSP
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      req_ready_q, req_ready_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic            b_ready_q, b_ready_d;
  logic            ar_valid_q, ar_valid_d;
  logic            r_ready_q, r_ready_d;
  logic [DW-1:0]   cap_data_q, cap_data_d;
  logic [1:0]      cap_resp_q, cap_resp_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic            g;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;

  // Contention goes to whoever did not win last time; a lone requester always wins.
  always_comb begin
    if (&bus.C_REQ_VALID) g = ~last_grant_q;
    else                  g = bus.C_REQ_VALID[1];
    sel_wr    = g ? bus.C_REQ_WR[1]                : bus.C_REQ_WR[0];
    sel_addr  = g ? bus.C_REQ_ADDR[2*AW-1:AW]      : bus.C_REQ_ADDR[AW-1:0];
    sel_wdata = g ? bus.C_REQ_WDATA[2*DW-1:DW]     : bus.C_REQ_WDATA[DW-1:0];
    sel_wstrb = g ? bus.C_REQ_WSTRB[2*SW-1:SW]     : bus.C_REQ_WSTRB[SW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    req_ready_d  = 2'b00;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    b_ready_d    = b_ready_q;
    ar_valid_d   = ar_valid_q;
    r_ready_d    = r_ready_q;
    cap_data_d   = cap_data_q;
    cap_resp_d   = cap_resp_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.C_REQ_VALID) begin
          grant_d      = g;
          last_grant_d = g;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          wstrb_d      = sel_wstrb;
          req_ready_d  = g ? 2'b10 : 2'b01;
          if (sel_wr) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = S_WR_AW_W;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = S_RD_AR;
          end
        end
      end
      // AW and W complete independently, in either order.
      S_WR_AW_W: begin
        if (aw_valid_q && bus.M_AXI_AW_READY) aw_valid_d = 1'b0;
        if (w_valid_q && bus.M_AXI_W_READY)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_B;
        end
      end
      S_WR_B: begin
        if (bus.M_AXI_B_VALID && b_ready_q) begin
          cap_data_d = '0;
          cap_resp_d = bus.M_AXI_B_RESP;
          b_ready_d  = 1'b0;
          state_d    = S_RSP;
        end
      end
      S_RD_AR: begin
        if (ar_valid_q && bus.M_AXI_AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_R;
        end
      end
      S_RD_R: begin
        if (bus.M_AXI_R_VALID && r_ready_q) begin
          cap_data_d = bus.M_AXI_R_DATA;
          cap_resp_d = bus.M_AXI_R_RESP;
          r_ready_d  = 1'b0;
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        rsp_rdata_d = cap_data_q;
        rsp_resp_d  = cap_resp_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      req_ready_q  <= 2'b00;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      cap_data_q   <= '0;
      cap_resp_q   <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      req_ready_q  <= req_ready_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      b_ready_q    <= b_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      cap_data_q   <= cap_data_d;
      cap_resp_q   <= cap_resp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
    end
  end

  assign bus.C_REQ_READY    = req_ready_q;
  assign bus.C_RSP_VALID    = rsp_valid_q;
  assign bus.C_RSP_RDATA    = rsp_rdata_q;
  assign bus.C_RSP_RESP     = rsp_resp_q;
  assign bus.M_AXI_AW_ADDR  = addr_q;
  assign bus.M_AXI_AW_PROT  = 3'b000;
  assign bus.M_AXI_AW_VALID = aw_valid_q;
  assign bus.M_AXI_W_DATA   = wdata_q;
  assign bus.M_AXI_W_STRB   = wstrb_q;
  assign bus.M_AXI_W_VALID  = w_valid_q;
  assign bus.M_AXI_B_READY  = b_ready_q;
  assign bus.M_AXI_AR_ADDR  = addr_q;
  assign bus.M_AXI_AR_PROT  = 3'b000;
  assign bus.M_AXI_AR_VALID = ar_valid_q;
  assign bus.M_AXI_R_READY  = r_ready_q;

`ifdef AXI_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, err_q, err_d;

  // Counters follow the registered response pulse and stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    if (rsp_valid_q[0] && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (rsp_valid_q[1] && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    if ((|rsp_valid_q) && rsp_resp_q != 2'b00 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      err_q  <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      err_q  <= err_d;
    end
  end

  assign STAT_CNT0 = cnt0_q;
  assign STAT_CNT1 = cnt1_q;
  assign STAT_ERR  = err_q;
`endif
endmodule

// File: tb/tb_axi_lite_master_arb.sv
// Directed bench for axi_lite_master_arb with a behavioural 4-register AXI4-Lite slave
// whose handshake delays and responses are set per step.
module tb_axi_lite_master_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_master_arb_if #(.DW(32), .AW(4)) bus ();

`ifdef AXI_ARB_STATS_EN
  logic [15:0] stat0, stat1, staterr;
`endif

  axi_lite_master_arb #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .bus          (bus)
`ifdef AXI_ARB_STATS_EN
    ,
    .STAT_CNT0    (stat0),
    .STAT_CNT1    (stat1),
    .STAT_ERR     (staterr)
`endif
  );

  // requester-side drive
  logic        v0 = 0, v1 = 0, w0 = 0, w1 = 0;
  logic [3:0]  a0 = 0, a1 = 0, s0 = 0, s1 = 0;
  logic [31:0] d0 = 0, d1 = 0;
  assign bus.C_REQ_VALID = {v1, v0};
  assign bus.C_REQ_WR    = {w1, w0};
  assign bus.C_REQ_ADDR  = {a1, a0};
  assign bus.C_REQ_WDATA = {d1, d0};
  assign bus.C_REQ_WSTRB = {s1, s0};

  // behavioural slave
  int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] sregs [4];
  int          aw_cnt, w_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend, b_valid, r_valid;
  logic [3:0]  aw_a, w_s;
  logic [31:0] w_d, r_dat;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [3:0]  wa, ws;
  logic [31:0] wd;

  assign bus.M_AXI_AW_READY = bus.M_AXI_AW_VALID && (aw_cnt >= aw_dly);
  assign bus.M_AXI_W_READY  = bus.M_AXI_W_VALID && (w_cnt >= w_dly);
  assign bus.M_AXI_AR_READY = bus.M_AXI_AR_VALID;
  assign bus.M_AXI_B_VALID  = b_valid;
  assign bus.M_AXI_B_RESP   = b_valid ? b_resp_cfg : 2'b00;
  assign bus.M_AXI_R_VALID  = r_valid;
  assign bus.M_AXI_R_DATA   = r_dat;
  assign bus.M_AXI_R_RESP   = r_resp_cfg;
  assign aw_hs   = bus.M_AXI_AW_VALID && bus.M_AXI_AW_READY;
  assign w_hs    = bus.M_AXI_W_VALID && bus.M_AXI_W_READY;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wa      = aw_hs ? bus.M_AXI_AW_ADDR : aw_a;
  assign wd      = w_hs ? bus.M_AXI_W_DATA : w_d;
  assign ws      = w_hs ? bus.M_AXI_W_STRB : w_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sregs[0] <= 32'h0; sregs[1] <= 32'h0; sregs[2] <= 32'h2; sregs[3] <= 32'h0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0; b_valid <= 0; r_valid <= 0;
      aw_a <= 0; w_s <= 0; w_d <= 0; r_dat <= 0;
    end else begin
      aw_cnt <= (bus.M_AXI_AW_VALID && !bus.M_AXI_AW_READY) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.M_AXI_W_VALID && !bus.M_AXI_W_READY) ? w_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1; aw_a <= bus.M_AXI_AW_ADDR; end
      if (w_hs) begin w_got <= 1; w_d <= bus.M_AXI_W_DATA; w_s <= bus.M_AXI_W_STRB; end
      if (aw_have && w_have) begin
        for (int k = 0; k < 4; k++)
          if (ws[k]) sregs[wa[3:2]][k*8 +: 8] <= wd[k*8 +: 8];
        aw_got <= 0;
        w_got  <= 0;
        if (b_dly == 0) b_valid <= 1;
        else begin b_pend <= 1; b_cnt <= b_dly; end
      end
      if (b_pend) begin
        if (b_cnt == 1) begin b_valid <= 1; b_pend <= 0; end
        else b_cnt <= b_cnt - 1;
      end
      if (b_valid && bus.M_AXI_B_READY) b_valid <= 0;
      if (bus.M_AXI_AR_VALID) begin
        r_dat <= sregs[bus.M_AXI_AR_ADDR[3:2]];
        if (r_dly == 0) r_valid <= 1;
        else begin r_pend <= 1; r_cnt <= r_dly; end
      end
      if (r_pend) begin
        if (r_cnt == 1) begin r_valid <= 1; r_pend <= 0; end
        else r_cnt <= r_cnt - 1;
      end
      if (r_valid && bus.M_AXI_R_READY) r_valid <= 0;
    end
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_asrt++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // bus monitor: grant order, response counts, B handshakes, VALID/READY hold rules
  int grants[$];
  int rsp_cnt0 = 0, rsp_cnt1 = 0, b_hs_cnt = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic p_br = 0, p_bv = 0, p_rr = 0, p_rv = 0;

  always @(negedge clk) begin
    if (rst) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br, p_bv, p_rr, p_rv} = '0;
    end else begin
      if (p_awv && !p_awr) chk("aw_valid_hold", {31'd0, bus.M_AXI_AW_VALID}, 32'd1);
      if (p_wv && !p_wr)   chk("w_valid_hold", {31'd0, bus.M_AXI_W_VALID}, 32'd1);
      if (p_arv && !p_arr) chk("ar_valid_hold", {31'd0, bus.M_AXI_AR_VALID}, 32'd1);
      if (p_br && !p_bv)   chk("b_ready_hold", {31'd0, bus.M_AXI_B_READY}, 32'd1);
      if (p_rr && !p_rv)   chk("r_ready_hold", {31'd0, bus.M_AXI_R_READY}, 32'd1);
      if (bus.C_REQ_READY[0]) grants.push_back(0);
      if (bus.C_REQ_READY[1]) grants.push_back(1);
      if (bus.C_RSP_VALID[0]) rsp_cnt0++;
      if (bus.C_RSP_VALID[1]) rsp_cnt1++;
      if (bus.M_AXI_B_VALID && bus.M_AXI_B_READY) b_hs_cnt++;
      p_awv = bus.M_AXI_AW_VALID; p_awr = bus.M_AXI_AW_READY;
      p_wv  = bus.M_AXI_W_VALID;  p_wr  = bus.M_AXI_W_READY;
      p_arv = bus.M_AXI_AR_VALID; p_arr = bus.M_AXI_AR_READY;
      p_br  = bus.M_AXI_B_READY;  p_bv  = bus.M_AXI_B_VALID;
      p_rr  = bus.M_AXI_R_READY;  p_rv  = bus.M_AXI_R_VALID;
    end
  end

  // Issue one command from requester i; called at a negedge. Returns the negedge
  // count at which C_RSP_VALID[i] was seen and a snapshot of the bus at the 3rd negedge.
  task automatic issue(input int i, input logic wr, input logic [3:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic [1:0] resp,
                       output int lat, output logic [5:0] pvec);
    if (i == 0) begin w0 = wr; a0 = addr; d0 = data; s0 = strb; v0 = 1; end
    else        begin w1 = wr; a1 = addr; d1 = data; s1 = strb; v1 = 1; end
    lat = -1; rdata = '0; resp = '0; pvec = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 3) pvec = {bus.M_AXI_AW_VALID, bus.M_AXI_W_VALID, bus.M_AXI_B_READY,
                          bus.M_AXI_B_VALID, bus.M_AXI_R_READY, bus.M_AXI_R_VALID};
      if (bus.C_REQ_READY[i]) begin
        if (i == 0) v0 = 0; else v1 = 0;
      end
      if (bus.C_RSP_VALID[i]) begin
        rdata = bus.C_RSP_RDATA;
        resp  = bus.C_RSP_RESP;
        lat   = c;
        break;
      end
    end
    if (lat < 0) begin
      fail_now($sformatf("issue_timeout_req%0d", i));
      v0 = 0; v1 = 0;
    end
  endtask

  task automatic stream(input int i);
    int n;
    for (int k = 0; k < 4; k++) begin
      if (i == 0) begin w0 = 1; a0 = 4'h0; d0 = k; s0 = 4'hF; v0 = 1; end
      else        begin w1 = 0; a1 = 4'hC; d1 = 0; s1 = 4'h0; v1 = 1; end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.C_REQ_READY[i] && n < 40);
      if (!bus.C_REQ_READY[i]) fail_now($sformatf("stream_ready_timeout_req%0d", i));
    end
    if (i == 0) v0 = 0; else v1 = 0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          lat, n, b0;
  logic [5:0]  pv;

  initial begin
    // both requesters valid out of reset, 4 commands each
    fork
      stream(0);
      stream(1);
      begin
        @(negedge clk);
        chk("rst_req_ready", {30'd0, bus.C_REQ_READY}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.C_RSP_VALID}, 32'd0);
        chk("rst_rsp_rdata", bus.C_RSP_RDATA, 32'd0);
        chk("rst_rsp_resp", {30'd0, bus.C_RSP_RESP}, 32'd0);
        chk("rst_axi_valids", {27'd0, bus.M_AXI_AW_VALID, bus.M_AXI_W_VALID, bus.M_AXI_B_READY,
                               bus.M_AXI_AR_VALID, bus.M_AXI_R_READY}, 32'd0);
        chk("rst_addr_data", {bus.M_AXI_AW_ADDR, bus.M_AXI_AR_ADDR, bus.M_AXI_W_STRB, 20'd0} | bus.M_AXI_W_DATA, 32'd0);
        chk("rst_prot", {26'd0, bus.M_AXI_AW_PROT, bus.M_AXI_AR_PROT}, 32'd0);
`ifdef AXI_ARB_STATS_EN
        chk("rst_stats", {stat0, stat1 | staterr}, 32'd0);
`endif
        @(negedge clk);
        rst = 0;
      end
    join
    n = 0;
    while (rsp_cnt1 < 4 && n < 30) begin @(negedge clk); n++; end
    chk("stream_grant_count", grants.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < grants.size()) chk($sformatf("stream_grant%0d", k), grants[k], k % 2);
    chk("stream_rsp_cnt0", rsp_cnt0, 32'd4);
    chk("stream_rsp_cnt1", rsp_cnt1, 32'd4);
    @(negedge clk);

    // basic write/read, minimum latency
    issue(0, 1, 4'h4, 32'hA5A5_1234, 4'hF, rd, rs, lat, pv);
    chk("wr04_lat", lat, 32'd4);
    chk("wr04_rdata", rd, 32'd0);
    chk("wr04_resp", {30'd0, rs}, 32'd0);
    chk("wr04_probe", {26'd0, pv}, 32'd0);
    issue(0, 0, 4'h4, 32'h0, 4'h0, rd, rs, lat, pv);
    chk("rd04_lat", lat, 32'd4);
    chk("rd04_rdata", rd, 32'hA5A5_1234);
    chk("rd04_resp", {30'd0, rs}, 32'd0);
    chk("stream_reg0", sregs[0], 32'd3);

    // byte strobe on reg 0x8 (reset value 0x2), read back through requester 1
    issue(0, 1, 4'h8, 32'hFFFF_FFFF, 4'b0010, rd, rs, lat, pv);
    issue(1, 0, 4'h8, 32'h0, 4'h0, rd, rs, lat, pv);
    chk("strb_rdata", rd, 32'h0000_FF02);
    chk("strb_lat_req1", lat, 32'd4);

    // AW/W ordering
    aw_dly = 0; w_dly = 3; b0 = b_hs_cnt;
    issue(0, 1, 4'hC, 32'h1111_0001, 4'hF, rd, rs, lat, pv);
    chk("w_late_lat", lat, 32'd7);
    chk("w_late_probe", {26'd0, pv}, 32'b010000);
    chk("w_late_bcount", b_hs_cnt - b0, 32'd1);
    aw_dly = 3; w_dly = 0; b0 = b_hs_cnt;
    issue(1, 1, 4'hC, 32'h2222_0002, 4'hF, rd, rs, lat, pv);
    chk("aw_late_lat", lat, 32'd7);
    chk("aw_late_probe", {26'd0, pv}, 32'b100000);
    chk("aw_late_bcount", b_hs_cnt - b0, 32'd1);
    aw_dly = 2; w_dly = 2; b0 = b_hs_cnt;
    issue(0, 1, 4'hC, 32'h3333_0003, 4'hF, rd, rs, lat, pv);
    chk("aw_w_same_lat", lat, 32'd6);
    chk("aw_w_same_probe", {26'd0, pv}, 32'b110000);
    chk("aw_w_same_bcount", b_hs_cnt - b0, 32'd1);
    chk("reg_c_value", sregs[3], 32'h3333_0003);
    aw_dly = 0; w_dly = 0;

    // slow B and R with SLVERR
    b_dly = 5; b_resp_cfg = 2'b10;
    issue(0, 1, 4'hC, 32'h4444_0004, 4'hF, rd, rs, lat, pv);
    chk("b_slow_lat", lat, 32'd9);
    chk("b_slow_resp", {30'd0, rs}, 32'd2);
    chk("b_slow_probe", {26'd0, pv}, 32'b001000);
    b_dly = 0; b_resp_cfg = 2'b00;
    r_dly = 7; r_resp_cfg = 2'b10;
    issue(1, 0, 4'h4, 32'h0, 4'h0, rd, rs, lat, pv);
    chk("r_slow_lat", lat, 32'd11);
    chk("r_slow_resp", {30'd0, rs}, 32'd2);
    chk("r_slow_rdata", rd, 32'hA5A5_1234);
    chk("r_slow_probe", {26'd0, pv}, 32'b000010);
    r_dly = 0; r_resp_cfg = 2'b00;

    // reset while waiting for B
    b_dly = 10;
    w0 = 1; a0 = 4'h0; d0 = 32'h5555_0005; s0 = 4'hF; v0 = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.C_REQ_READY[0]) v0 = 0;
    end while (!bus.M_AXI_B_READY && n < 20);
    v0 = 0;
    chk("wrb_reached", {31'd0, bus.M_AXI_B_READY}, 32'd1);
    rst = 1;
    #1;
    chk("mid_rst_axi_valids", {27'd0, bus.M_AXI_AW_VALID, bus.M_AXI_W_VALID, bus.M_AXI_B_READY,
                               bus.M_AXI_AR_VALID, bus.M_AXI_R_READY}, 32'd0);
    chk("mid_rst_client", {28'd0, bus.C_REQ_READY, bus.C_RSP_VALID}, 32'd0);
    chk("mid_rst_rsp", {30'd0, bus.C_RSP_RESP} | bus.C_RSP_RDATA, 32'd0);
    @(negedge clk);
    @(negedge clk);
    b_dly = 0;
    rst = 0;
`ifdef AXI_ARB_STATS_EN
    chk("post_rst_stats", {stat0, stat1 | staterr}, 32'd0);
`endif
    issue(0, 0, 4'h4, 32'h0, 4'h0, rd, rs, lat, pv);
    chk("post_rst_rd_lat", lat, 32'd4);
    chk("post_rst_rd_data", rd, 32'd0);
    @(negedge clk);
`ifdef AXI_ARB_STATS_EN
    chk("post_rst_stat0", {16'd0, stat0}, 32'd1);
    chk("post_rst_stat1_err", {stat1, staterr}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
